// File: rtl/fmcw_pkg.sv
// Shared definitions for the FMCW receive path.
//
// Purpose:
//   Configuration field positions, the decimation limit, the packed {Q, I}
//   sample types passed between axis_iq_boxcar_decim and axis_fmcw_window,
//   and a helper that converts a decimation exponent into a phase mask.
//
// Contents:
//   CFG_R_LSB / CFG_R_MSB : position of R inside cfg_data
//   R_MAX                 : largest decimation exponent (2^7 = 128)
//   CNT_W                 : width of the phase counter
//   iq_in_t / iq_out_t    : packed {Q, I} samples at ADC and integrated widths
//   blk_mask()            : 2^r - 1, i.e. the phase value of the last beat
package fmcw_pkg;

  localparam int CFG_R_LSB = 0;
  localparam int CFG_R_MSB = 2;
  localparam int R_MAX     = 7;
  localparam int CNT_W     = R_MAX;

  // Component widths of the packed stream types.
  localparam int IQ_IN_W   = 16;
  localparam int IQ_OUT_W  = 24;

  // {Q, I} with I in the LSBs, matching the AXI-Stream tdata layout.
  typedef struct packed {
    logic signed [IQ_IN_W-1:0] q;
    logic signed [IQ_IN_W-1:0] i;
  } iq_in_t;

  typedef struct packed {
    logic signed [IQ_OUT_W-1:0] q;
    logic signed [IQ_OUT_W-1:0] i;
  } iq_out_t;

  // Phase value of the final beat of a 2^r block: all-ones in the low r bits.
  function automatic logic [CNT_W-1:0] blk_mask(input logic [2:0] r);
    return 7'h7F >> (3'd7 - r);
  endfunction

endpackage

// File: rtl/iq_accum.sv
// Per-component block accumulator.
//
// Purpose:
//   Holds the running sum of one I or Q component. The combinational sum
//   (stored partial sum + current sample) is exported so the parent can load
//   it into its output register on the completing beat, while the stored
//   partial sum clears in the same cycle.
//
// Ports:
//   clk_i      : clock
//   rst_ni     : synchronous active-low reset, clears the partial sum
//   restart_i  : discard the partial sum this cycle (chirp restart)
//   accept_i   : an input beat is consumed this cycle
//   last_i     : the consumed beat completes the block
//   sample_i   : signed input component (IN_W bits)
//   sum_o      : partial sum + sign-extended sample (OUT_W bits)
module iq_accum #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 24
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    restart_i,
  input  logic                    accept_i,
  input  logic                    last_i,
  input  logic signed [IN_W-1:0]  sample_i,
  output logic signed [OUT_W-1:0] sum_o
);

  logic signed [OUT_W-1:0] acc_q;
  logic signed [OUT_W-1:0] acc_d;
  logic signed [OUT_W-1:0] acc_base;
  logic signed [OUT_W-1:0] sample_ext;

  // A restart makes the current beat the first of a fresh block.
  assign acc_base   = restart_i ? '0 : acc_q;
  assign sample_ext = {{(OUT_W-IN_W){sample_i[IN_W-1]}}, sample_i};
  assign sum_o      = acc_base + sample_ext;

  always_comb begin
    acc_d = acc_base;
    if (accept_i) begin
      acc_d = last_i ? '0 : sum_o;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/axis_iq_boxcar_decim.sv
// Boxcar I/Q decimator (integrate-and-dump) for the FMCW receive path.
//
// Purpose:
//   Sums 2^R consecutive complex samples into one output beat. The block
//   phase restarts on every rising edge of ramp so that downstream blocks
//   always receive whole, chirp-aligned blocks. The input cannot stall; a
//   result that completes while the single-entry output register is still
//   occupied and not being taken is dropped and counted.
//
// Build option:
//   AXIS_IQ_DECIM_NORM_EN defined : output is sum >>> R (block mean, floor)
//   undefined                     : raw sum (gain 2^R)
//
// Parameters:
//   IN_W  : signed width of each input component
//   OUT_W : signed width of each output component, must be >= IN_W + 7
//
// Ports:
//   aclk, aresetn          : clock, synchronous active-low reset
//   cfg_data[7:0]          : [2:0] = R, decimation 2^R; [7:3] ignored
//   ramp                   : chirp level; a rising edge restarts the block
//   sts_data[15:0]         : saturating count of dropped results
//   err_overrun            : one-cycle pulse per dropped result
//   s_axis_data_*          : input stream {Q, I}, tready 1 outside reset
//   m_axis_data_*          : output stream {Q_sum, I_sum}
module axis_iq_boxcar_decim
  import fmcw_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 24
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic [7:0]           cfg_data,
  input  logic                 ramp,
  output logic [15:0]          sts_data,
  output logic                 err_overrun,
  input  logic [2*IN_W-1:0]    s_axis_data_tdata,
  input  logic                 s_axis_data_tvalid,
  output logic                 s_axis_data_tready,
  output logic [2*OUT_W-1:0]   m_axis_data_tdata,
  output logic                 m_axis_data_tvalid,
  input  logic                 m_axis_data_tready
);

`ifdef AXIS_IQ_DECIM_NORM_EN
  localparam bit NORM_EN = 1'b1;
`else
  localparam bit NORM_EN = 1'b0;
`endif

  // Output scaling: arithmetic shift floors toward -inf.
  function automatic logic signed [OUT_W-1:0] norm(
    input logic signed [OUT_W-1:0] s,
    input logic [2:0]              r
  );
    return NORM_EN ? (s >>> r) : s;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Control state
  logic             tready_q;
  logic             ramp_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       r_q, r_d;

  // Output register
  logic                 vld_q, vld_d;
  logic [2*OUT_W-1:0]   data_q, data_d;
  logic [15:0]          sts_q, sts_d;
  logic                 err_q, err_d;

  logic [2:0]              cfg_r;
  logic [4:0]              unused_cfg;
  logic                    rise;
  logic                    accept;
  logic                    last;
  logic                    drop;
  logic [CNT_W-1:0]        cnt_base;
  logic signed [OUT_W-1:0] sum_i, sum_q;

  assign cfg_r      = cfg_data[CFG_R_MSB:CFG_R_LSB];
  assign unused_cfg = cfg_data[7:3];

  assign rise   = ramp & ~ramp_q;
  assign accept = s_axis_data_tvalid & tready_q;

  // A restart discards the partial block; the current beat (if any) is the
  // first beat of the new block. R is taken from cfg at every block start.
  assign cnt_base = rise ? '0 : cnt_q;
  assign r_d      = (rise || (cnt_q == '0)) ? cfg_r : r_q;

  // The completing beat is judged against the restarted phase, so a ramp
  // edge landing on the old block's last beat never emits the partial sum.
  // With R = 0 the restart beat forms a complete one-sample block itself.
  assign last = accept && (cnt_base == blk_mask(r_d));
  assign drop = last && vld_q && !m_axis_data_tready;

  always_comb begin
    cnt_d = cnt_base;
    if (accept) begin
      cnt_d = last ? '0 : cnt_base + 7'd1;
    end
  end

  iq_accum #(.IN_W(IN_W), .OUT_W(OUT_W)) u_acc_i (
    .clk_i     (aclk),
    .rst_ni    (aresetn),
    .restart_i (rise),
    .accept_i  (accept),
    .last_i    (last),
    .sample_i  (s_axis_data_tdata[IN_W-1:0]),
    .sum_o     (sum_i)
  );

  iq_accum #(.IN_W(IN_W), .OUT_W(OUT_W)) u_acc_q (
    .clk_i     (aclk),
    .rst_ni    (aresetn),
    .restart_i (rise),
    .accept_i  (accept),
    .last_i    (last),
    .sample_i  (s_axis_data_tdata[2*IN_W-1:IN_W]),
    .sum_o     (sum_q)
  );

  // A completion coinciding with a handshake reloads the register and keeps
  // tvalid high; one arriving while the held beat is stalled is dropped.
  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    sts_d  = sts_q;
    err_d  = 1'b0;
    if (last) begin
      if (drop) begin
        err_d = 1'b1;
        sts_d = sat_inc16(sts_q);
      end else begin
        vld_d  = 1'b1;
        data_d = {norm(sum_q, r_d), norm(sum_i, r_d)};
      end
    end else if (vld_q && m_axis_data_tready) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      tready_q <= 1'b0;
      ramp_q   <= 1'b0;
      cnt_q    <= '0;
      r_q      <= '0;
      vld_q    <= 1'b0;
      data_q   <= '0;
      sts_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      tready_q <= 1'b1;
      ramp_q   <= ramp;
      cnt_q    <= cnt_d;
      r_q      <= r_d;
      vld_q    <= vld_d;
      data_q   <= data_d;
      sts_q    <= sts_d;
      err_q    <= err_d;
    end
  end

  assign s_axis_data_tready = tready_q;
  assign m_axis_data_tvalid = vld_q;
  assign m_axis_data_tdata  = data_q;
  assign sts_data           = sts_q;
  assign err_overrun        = err_q;

endmodule

// File: doc/axis_iq_boxcar_decim.md
# axis_iq_boxcar_decim

Boxcar decimator for the FMCW receive path. It integrates 2^R consecutive complex ADC samples (16-bit I/Q) into one 48-bit {Q[23:0], I[23:0]} AXI-Stream beat. It sits directly upstream of `axis_fmcw_window` and drives that block's `s_axis_data_*` port. The decimation phase restarts on every chirp `ramp` edge, so the window stage always receives whole, ramp-aligned blocks.

## Interface
- `IN_W`, 16: signed width of each input I/Q component.
- `OUT_W`, 24: signed width of each output I/Q component; requires OUT_W ≥ IN_W + 7.
- `aclk` in 1: sole clock.
- `aresetn` in 1: reset, synchronous, active-low.
- `cfg_data` in 8: [2:0] = R, where decimation = 2^R (1..128). [7:3] reserved, ignored.
- `ramp` in 1: chirp-start strobe, level, synchronous to `aclk`.
- `sts_data` out 16: count of dropped output beats, saturating.
- `err_overrun` out 1: one-cycle pulse when a completed result is dropped.
- `s_axis_data_tdata` in 2*IN_W: {Q, I}, I in the LSBs.
- `s_axis_data_tvalid` in 1: input beat valid.
- `s_axis_data_tready` out 1: tied 1 outside reset. The ADC stream cannot stall.
- `m_axis_data_tdata` out 2*OUT_W: {Q_sum, I_sum}.
- `m_axis_data_tvalid` out 1: output beat valid.
- `m_axis_data_tready` in 1: downstream ready.

## Operation
- Each accepted input beat (tvalid & tready) adds the sign-extended I and Q into two OUT_W accumulators and increments the phase counter `cnt` (7 bits).
- R is latched into `r_q` whenever `cnt` == 0 and a beat is accepted. A cfg change in mid-block takes effect at the next block.
- Block completion is the beat accepted while `cnt` == 2^r_q − 1. On completion:
  - the final sum (accumulator + current sample) is loaded into the output register;
  - the accumulators and `cnt` clear.
- Ramp edge: `rise = ramp & ~ramp_q`, with `ramp_q` registered.
  - In the `rise` cycle, any partial block is discarded: accumulators load the current beat if one is accepted, otherwise 0, and `cnt` = (beat accepted ? 1 : 0).
  - R is relatched in that cycle.
  - A pending output beat is unaffected.
- Output register, single entry:
  - If a completion occurs while the register holds an unaccepted beat and `m_axis_data_tready` = 0, the new result is dropped. `err_overrun` pulses and `sts_data` increments, saturating at 0xFFFF.
  - If a completion occurs in the same cycle as an output handshake, the new result is loaded and `m_axis_data_tvalid` stays 1.
- Arithmetic:
  - Two's complement throughout.
  - No overflow is possible: the maximum magnitude is 128·2^(IN_W−1).
  - R = 0 gives pass-through with sign extension.

## Timing
- Reset values: `m_axis_data_tvalid` 0, `m_axis_data_tdata` 0, `sts_data` 0, `err_overrun` 0, `s_axis_data_tready` 0 during reset and 1 from the first cycle after reset.
- Internal state cleared by reset: accumulators, `cnt`, `r_q`, `ramp_q`.
- Latency: `m_axis_data_tvalid` rises on the clock edge after the completing input beat, i.e. 1 cycle.
- Output handshake: tdata is held stable while tvalid=1 and tready=0. tvalid drops the cycle after a handshake unless a new completion coincides with it.
- `ramp` held high for many cycles produces only one restart.
- `ramp` rising in the same cycle as a completion: the restart wins. The partial sum is discarded and no output is produced.
- Reset asserted mid-block: all state is lost and no output beat is produced.

## Configuration
- `AXIS_IQ_DECIM_NORM_EN` defined: output is `sum >>> r_q`, an arithmetic shift that truncates toward −inf. This is the block mean, scaled like the input.
- Macro undefined: raw sum output, giving gain 2^R.
- Latency, handshake and error behaviour are identical in both builds.

## Structure
- Package `fmcw_pkg` holds:
  - `CFG_R_LSB` / `CFG_R_MSB` field positions;
  - `R_MAX` = 7;
  - a typedef for the packed {Q, I} sample, parameterised by width, shared with `axis_fmcw_window`.
- One sub-module, `iq_accum`: a per-component accumulate/clear/load unit, instantiated twice (I, Q).
- Phase counter, ramp edge logic and output register stay in the top module.

## Test plan
- R=2, input I=Q=1,2,3,4,5,6,7,8 on consecutive cycles, tready=1 -> two beats, I=Q=10 then 26, each one cycle after the 4th and 8th inputs. With NORM_EN: 2 then 6.
- R=0, I=−5, Q=7 -> one output per input, I=−5 (0xFFFFFB), Q=7, latency 1.
- R=3, 5 inputs of value 1, then ramp rises with an input of value 2, then 7 inputs of value 1 -> the first output is 9. The partial sum 5 never appears.
- R=1, tready held 0 across 3 completions -> first beat held stable, `err_overrun` pulses twice, `sts_data` = 2.
- cfg changed from R=1 to R=3 mid-block -> the current block completes with 2 samples; the next block uses 8.
- Reset asserted after 3 of 4 samples (R=2), then 4 fresh samples of value 1 -> single output of 4. No spurious beat.
